lives_display: RTL and testbench
================================

LIVES_DISPLAY -- requirements
Module: lives_display

Interface
REQ-001 Parameter MAX_LIVES, default 6: number of life-icon slots (1..7).
REQ-002 Parameter ICON_X0, default 50: x of first icon's left edge.
REQ-003 Parameter ICON_W, default 40; ICON_GAP, default 10: icon width and spacing in pixels; slot pitch = ICON_W+ICON_GAP.
REQ-004 Parameter BAND_TOP, default 460; BAND_BOTTOM, default 480: scoreboard band y limits, inclusive.
REQ-005 Parameter BLINK_FRAMES, default 64; BLINK_HALF, default 8: blink duration and half-period, both in frames.
REQ-006 clk  in  1  pixel clock; one clock; reset is synchronous and active-high.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 mode  in  2  game mode; 2 = playing, rendering enabled.
REQ-009 lives  in  3  current extra-lives count from game logic.
REQ-010 xCoord, yCoord  in  11 each  current pixel coordinates.
REQ-011 rgb  out  8  pixel colour [blue|green|red], registered.
REQ-012 is_scoreboard_bottom  out  1  pixel lies in the band, registered.

Function
REQ-013 frame_tick SHALL be (xCoord==0 && yCoord==0); all state updates except the output register occur only on frame_tick.
REQ-014 On frame_tick, lives_in = min(lives, MAX_LIVES) SHALL be loaded into lives_q.
REQ-015 FSM SHALL have states IDLE and BLINK, plus blink_lo/blink_hi (3b), frame counter blink_cnt, and phase bit.
REQ-016 IDLE->BLINK on frame_tick when mode==2 and lives_in<lives_q: blink_lo=lives_in, blink_hi=lives_q-1, blink_cnt=BLINK_FRAMES-1, phase=0 (lost icons hidden).
REQ-017 In BLINK, each frame_tick: blink_cnt decrements; phase toggles whenever the number of frames elapsed since entry is a nonzero multiple of BLINK_HALF; at blink_cnt==0, return to IDLE.
REQ-018 In BLINK, further loss (lives_in<lives_q): restart blink with blink_lo=lives_in, blink_hi=max(blink_hi, lives_q-1), counter reloaded, phase=0.
REQ-019 In BLINK, gain (lives_in>lives_q) SHALL abort to IDLE on that frame_tick; equal count leaves the blink running.
REQ-020 Whenever mode!=2 at frame_tick: state forced IDLE, lives_q still loaded, no blink started.
REQ-021 Icon k (0..MAX_LIVES-1) region: x in [ICON_X0+k*pitch, ICON_X0+k*pitch+ICON_W-1], y in [BAND_TOP+5, BAND_BOTTOM-5].
REQ-022 Icon k SHALL be lit if k<lives_q, or if state==BLINK and blink_lo<=k<=blink_hi and phase==1.
REQ-023 Pixel colour, priority order, when mode==2 and y in [BAND_TOP,BAND_BOTTOM]: x in 1..9 or 631..639 -> 8'hFF; lit icon region -> 8'h78; else 8'h00.
REQ-024 Outside the band, or mode!=2: rgb=8'h00, is_scoreboard_bottom=0.
REQ-025 is_scoreboard_bottom SHALL be 1 for every band pixel when mode==2, including black pixels.
REQ-026 rgb and is_scoreboard_bottom SHALL be registered every clock: exactly 1-cycle latency from xCoord/yCoord, using lives_q/FSM values current in that cycle.
REQ-027 Coordinate arithmetic SHALL be at least 11 bits wide, with no truncation for MAX_LIVES up to 7.

Reset
REQ-028 While rst=1 at a clock edge: rgb=0, is_scoreboard_bottom=0, lives_q=0, state=IDLE, blink_cnt=0, phase=0, blink_lo=blink_hi=0.
REQ-029 rst SHALL take priority over frame_tick; reset during BLINK aborts the blink immediately.
REQ-030 First frame_tick after reset with lives>0 is a gain: icons appear, no blink.

Verification
REQ-031 Reset, mode=2, lives=3, one frame -> pixel (55,470) rgb=8'h78 one cycle later; (155,470) 8'h78; (205,470) 8'h00; (5,465) 8'hFF; flag 1 on all.
REQ-032 lives 3->2 at frame N -> icon 2 (x 150..189) dark frames N..N+7, lit N+8..N+15, alternating; after 64 frames permanently dark, state IDLE.
REQ-033 lives=7 with MAX_LIVES=6 -> exactly 6 icons lit, x 300..339 lit, x 350 dark.
REQ-034 During blink (3->2), lives 2->3 -> blink aborts on that frame, icon 2 steadily lit; during blink, 2->1 -> icons 1..2 blink, counter restarts.
REQ-035 mode=1 with lives=3 -> rgb=0, flag 0 at (55,470); lives 3->1 then mode=2 -> no blink, 1 icon lit.
REQ-036 rst asserted mid-blink for one cycle -> next cycle rgb=0, flag 0, state IDLE; subsequent frame shows icons per REQ-030.

Source files
------------

// File: rtl/lives_display.sv
// lives_display: draws the remaining-lives icons in the bottom scoreboard band.
// When a life is lost, the lost icons blink for a while before going dark.
//
// Ports
//   clk                   pixel clock
//   rst                   synchronous active-high reset
//   mode[1:0]             game mode; 2 = playing (rendering enabled)
//   lives[2:0]            extra-lives count from game logic
//   xCoord[10:0]          current pixel x
//   yCoord[10:0]          current pixel y
//   rgb[7:0]              registered pixel colour {blue, green, red}
//   is_scoreboard_bottom  registered flag: pixel lies in the band
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | icons reflect lives_q only
// BLINK | icons blink_lo..blink_hi toggle with phase until blink_cnt runs out
module lives_display #(
   parameter int MAX_LIVES    = 6,
   parameter int ICON_X0      = 50,
   parameter int ICON_W       = 40,
   parameter int ICON_GAP     = 10,
   parameter int BAND_TOP     = 460,
   parameter int BAND_BOTTOM  = 480,
   parameter int BLINK_FRAMES = 64,
   parameter int BLINK_HALF   = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  mode,
   input  logic [2:0]  lives,
   input  logic [10:0] xCoord,
   input  logic [10:0] yCoord,
   output logic [7:0]  rgb,
   output logic        is_scoreboard_bottom
);

   localparam int PITCH  = ICON_W + ICON_GAP;
   localparam int CNT_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam int HALF_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

   typedef enum logic {IDLE, BLINK} state_t;

   state_t              state, state_n;
   logic [2:0]          lives_q, lives_q_n;
   logic [2:0]          blink_lo, blink_lo_n;
   logic [2:0]          blink_hi, blink_hi_n;
   logic [CNT_W-1:0]    blink_cnt, blink_cnt_n;
   logic [HALF_W-1:0]   half_cnt, half_cnt_n;
   logic                phase, phase_n;

   logic                frame_tick;
   logic                playing;
   logic [2:0]          lives_in;
   logic [2:0]          lost_hi;
   logic [7:0]          rgb_n;
   logic                band_n;

   assign frame_tick = (xCoord == 11'd0) && (yCoord == 11'd0);
   assign playing    = (mode == 2'd2);
   assign lives_in   = (lives > 3'(MAX_LIVES)) ? 3'(MAX_LIVES) : lives;
   // Only used on a loss, where lives_q > lives_in >= 0, so no underflow.
   assign lost_hi    = lives_q - 3'd1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state                <= IDLE;
         lives_q              <= '0;
         blink_lo             <= '0;
         blink_hi             <= '0;
         blink_cnt            <= '0;
         half_cnt             <= '0;
         phase                <= 1'b0;
         rgb                  <= 8'h00;
         is_scoreboard_bottom <= 1'b0;
      end else begin
         state                <= state_n;
         lives_q              <= lives_q_n;
         blink_lo             <= blink_lo_n;
         blink_hi             <= blink_hi_n;
         blink_cnt            <= blink_cnt_n;
         half_cnt             <= half_cnt_n;
         phase                <= phase_n;
         rgb                  <= rgb_n;
         is_scoreboard_bottom <= band_n;
      end
   end

   always_comb begin
      state_n     = state;
      lives_q_n   = lives_q;
      blink_lo_n  = blink_lo;
      blink_hi_n  = blink_hi;
      blink_cnt_n = blink_cnt;
      half_cnt_n  = half_cnt;
      phase_n     = phase;

      if (frame_tick) begin
         lives_q_n = lives_in;
         if (!playing) begin
            state_n     = IDLE;
            blink_cnt_n = '0;
            half_cnt_n  = '0;
            phase_n     = 1'b0;
         end else if (lives_in < lives_q) begin
            // New loss, or further loss while blinking: (re)start the blink,
            // widening the blinking range to cover everything lost so far.
            state_n     = BLINK;
            blink_lo_n  = lives_in;
            blink_hi_n  = (state == BLINK && blink_hi > lost_hi) ? blink_hi : lost_hi;
            blink_cnt_n = CNT_W'(BLINK_FRAMES - 1);
            half_cnt_n  = HALF_W'(BLINK_HALF - 1);
            phase_n     = 1'b0;
         end else if (state == BLINK) begin
            if (lives_in > lives_q || blink_cnt == '0) begin
               state_n     = IDLE;
               blink_cnt_n = '0;
               half_cnt_n  = '0;
               phase_n     = 1'b0;
            end else begin
               blink_cnt_n = blink_cnt - 1'b1;
               // half_cnt hits zero every BLINK_HALF frames after entry.
               if (half_cnt == '0) begin
                  phase_n    = ~phase;
                  half_cnt_n = HALF_W'(BLINK_HALF - 1);
               end else begin
                  half_cnt_n = half_cnt - 1'b1;
               end
            end
         end
      end
   end

   always_comb begin
      int  x, y, left;
      logic icon_hit, lit;
      x        = int'(xCoord);
      y        = int'(yCoord);
      icon_hit = 1'b0;
      rgb_n    = 8'h00;
      band_n   = 1'b0;

      for (int k = 0; k < MAX_LIVES; k++) begin
         left = ICON_X0 + k * PITCH;
         lit  = (k < int'(lives_q)) ||
                (state == BLINK && phase &&
                 k >= int'(blink_lo) && k <= int'(blink_hi));
         if (lit && x >= left && x <= left + ICON_W - 1 &&
             y >= BAND_TOP + 5 && y <= BAND_BOTTOM - 5)
            icon_hit = 1'b1;
      end

      if (playing && y >= BAND_TOP && y <= BAND_BOTTOM) begin
         band_n = 1'b1;
         if ((x >= 1 && x <= 9) || (x >= 631 && x <= 639))
            rgb_n = 8'hFF;
         else if (icon_hit)
            rgb_n = 8'h78;
      end
   end

endmodule

// File: tb/tb_lives_display.sv
module tb_lives_display;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  mode = 2'd2;
   logic [2:0]  lives = 3'd3;
   logic [10:0] xCoord = 11'd700;
   logic [10:0] yCoord = 11'd0;
   logic [7:0]  rgb;
   logic        is_scoreboard_bottom;

   typedef struct {
      string      tag;
      logic [7:0] rgb;
      logic       flag;
   } exp_t;

   exp_t sb[$];
   int   n_pass  = 0;
   int   n_total = 0;

   lives_display dut (
      .clk                  (clk),
      .rst                  (rst),
      .mode                 (mode),
      .lives                (lives),
      .xCoord               (xCoord),
      .yCoord               (yCoord),
      .rgb                  (rgb),
      .is_scoreboard_bottom (is_scoreboard_bottom)
   );

   always #5 clk = ~clk;

   task automatic pix(input string tag, input int x, input int y,
                      input logic [7:0] er, input logic ef);
      exp_t e;
      @(negedge clk);
      xCoord = 11'(x);
      yCoord = 11'(y);
      e.tag  = tag;
      e.rgb  = er;
      e.flag = ef;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      n_total++;
      assert (rgb === e.rgb && is_scoreboard_bottom === e.flag) n_pass++;
      else $error("FAIL %s: observed rgb=%h flag=%b expected rgb=%h flag=%b",
                  e.tag, rgb, is_scoreboard_bottom, e.rgb, e.flag);
   endtask

   task automatic tick();
      @(negedge clk);
      xCoord = 11'd0;
      yCoord = 11'd0;
      @(posedge clk);
      #1;
      xCoord = 11'd700;
      yCoord = 11'd0;
   endtask

   initial begin
      logic [7:0] e;

      // reset
      rst = 1'b1;
      pix("reset", 55, 470, 8'h00, 1'b0);
      pix("reset2", 5, 465, 8'h00, 1'b0);
      rst = 1'b0;
      pix("post_reset_no_icons", 55, 470, 8'h00, 1'b1);

      // first frame: gain to 3 lives, no blink
      tick();
      pix("icon0", 55, 470, 8'h78, 1'b1);
      pix("icon2", 155, 470, 8'h78, 1'b1);
      pix("icon2_right_edge", 189, 470, 8'h78, 1'b1);
      pix("gap_after_icon2", 190, 470, 8'h00, 1'b1);
      pix("icon3_dark", 205, 470, 8'h00, 1'b1);
      pix("left_border", 5, 465, 8'hFF, 1'b1);
      pix("band_above_icons", 55, 463, 8'h00, 1'b1);
      pix("above_band", 55, 459, 8'h00, 1'b0);
      pix("band_top_border", 9, 460, 8'hFF, 1'b1);
      pix("x0_not_border", 0, 470, 8'h00, 1'b1);

      // lose one life: icon 2 blinks 8 dark / 8 lit for 64 frames
      lives = 3'd2;
      for (int f = 0; f < 64; f++) begin
         tick();
         e = ((f / 8) % 2 == 1) ? 8'h78 : 8'h00;
         pix($sformatf("blink_f%0d", f), 155, 470, e, 1'b1);
         if (f == 9) pix("blink_icon1_steady", 105, 470, 8'h78, 1'b1);
      end
      for (int f = 64; f < 67; f++) begin
         tick();
         pix($sformatf("blink_done_f%0d", f), 155, 470, 8'h00, 1'b1);
      end

      // gain during blink aborts it
      lives = 3'd3;
      tick();
      lives = 3'd2;
      for (int f = 0; f < 4; f++) begin
         tick();
         pix($sformatf("pre_abort_f%0d", f), 155, 470, 8'h00, 1'b1);
      end
      lives = 3'd3;
      for (int f = 0; f < 12; f++) begin
         tick();
         pix($sformatf("abort_steady_f%0d", f), 155, 470, 8'h78, 1'b1);
      end

      // further loss restarts blink covering icons 1..2
      lives = 3'd2;
      for (int f = 0; f < 4; f++) tick();
      lives = 3'd1;
      for (int g = 0; g < 64; g++) begin
         tick();
         e = ((g / 8) % 2 == 1) ? 8'h78 : 8'h00;
         if (g < 17 || g == 63) begin
            pix($sformatf("reblink1_g%0d", g), 105, 470, e, 1'b1);
            pix($sformatf("reblink2_g%0d", g), 155, 470, e, 1'b1);
         end
         if (g == 3) pix("reblink_icon0", 55, 470, 8'h78, 1'b1);
      end
      tick();
      pix("reblink_done1", 105, 470, 8'h00, 1'b1);
      pix("reblink_done2", 155, 470, 8'h00, 1'b1);

      // lives clamped to MAX_LIVES
      lives = 3'd7;
      tick();
      pix("clamp_icon5", 300, 470, 8'h78, 1'b1);
      pix("clamp_icon5_edge", 339, 470, 8'h78, 1'b1);
      pix("clamp_no_icon6", 350, 470, 8'h00, 1'b1);
      pix("right_border", 631, 470, 8'hFF, 1'b1);
      pix("right_border_bot", 639, 480, 8'hFF, 1'b1);
      pix("past_border", 640, 470, 8'h00, 1'b1);
      pix("below_band", 55, 481, 8'h00, 1'b0);

      // non-playing mode: blank, and losses do not blink later
      mode  = 2'd1;
      lives = 3'd3;
      tick();
      pix("mode1_blank", 55, 470, 8'h00, 1'b0);
      pix("mode1_border_blank", 5, 470, 8'h00, 1'b0);
      lives = 3'd1;
      tick();
      mode = 2'd2;
      for (int f = 0; f < 12; f++) begin
         tick();
         pix($sformatf("mode2_icon1_dark_f%0d", f), 105, 470, 8'h00, 1'b1);
      end
      pix("mode2_icon0", 55, 470, 8'h78, 1'b1);

      // reset during a blink
      lives = 3'd3;
      tick();
      lives = 3'd2;
      for (int f = 0; f < 10; f++) tick();
      pix("pre_reset_blink_lit", 155, 470, 8'h78, 1'b1);
      rst = 1'b1;
      pix("mid_blink_reset", 155, 470, 8'h00, 1'b0);
      rst = 1'b0;
      pix("after_reset_icon0", 55, 470, 8'h00, 1'b1);
      for (int f = 0; f < 12; f++) begin
         tick();
         pix($sformatf("after_reset_icon2_f%0d", f), 155, 470, 8'h00, 1'b1);
      end
      pix("after_reset_icon0_lit", 55, 470, 8'h78, 1'b1);
      pix("after_reset_icon1_lit", 105, 470, 8'h78, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: observed no completion expected completion");
      $fatal(1, "timeout");
   end

endmodule
